nr4sd_serial_decoder: RTL and testbench
=======================================

# nr4sd_serial_decoder

Serial decoder from NR4SD digits back to N-bit two's complement, the inverse of the NR4SD-/+ recoding stage in the modified-Booth datapath. It accepts one recoded digit per handshake, least-significant digit first, and accumulates the radix-4 weighted sum. After the last digit it presents the reconstructed value, with overflow and digit-legality flags, on a valid/ready output. It serves as a checker and round-trip stage behind the recoder, and as the digit-to-binary converter for any digit-serial results in the multiplier.

## Interface
Parameters:
- N, 8: result width in bits; even, ≥4. Digit count D = N/2.
- MODE, 0: 0 = NR4SD- (non-MSD digits in {-2,-1,0,1}); 1 = NR4SD+ (non-MSD digits in {-1,0,1,2}). The MSD is always in {-2..2}.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  digit present.
- in_ready  out  1  block can accept a digit.
- onep  in  1  digit +1.
- onem  in  1  digit -1.
- twop  in  1  digit +2.
- twom  in  1  digit -2.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- out_data  out  N  reconstructed value, two's complement.
- out_ovf  out  1  sum does not fit in N bits signed.
- out_err  out  1  at least one illegal digit in this word.

## Operation
- A digit is accepted on a cycle where in_valid && in_ready.
- Digit value:
  - All four digit lines low = 0.
  - Exactly one line high = that line's value.
  - More than one line high is illegal: the digit is treated as 0 and the error flag is set.
- Position legality:
  - For i < D-1, MODE 0 forbids twop and MODE 1 forbids twom.
  - A forbidden digit is still accumulated at its nominal value and sets the error flag.
- Registers:
  - Signed accumulator acc, N+2 bits.
  - Digit index idx, 0..D-1.
  - Sticky error flag err_r.
- On each accepted digit i: acc <= acc + sext(d) << 2i, computed at N+2 bits. No intermediate overflow is possible.
- The first accepted digit of a word loads acc (acc <= d, not acc + d). It also loads err_r from that digit's legality (not OR-ed into the previous word's flag).
- State machine:
  - ACC → ACC when a digit is accepted and idx < D-1; idx increments.
  - ACC → DONE when digit D-1 is accepted. out_data, out_ovf and out_err are registered from the final sum in the same edge.
  - DONE → ACC when out_valid && out_ready; idx <= 0.
- Outputs by state:
  - in_ready = (state == ACC).
  - out_valid = (state == DONE).
  - No digit is accepted while in DONE.
- out_data = acc[N-1:0].
- out_ovf = 1 iff acc[N+1:N-1] are not all equal.
- out_err = err_r.
- out_data, out_ovf and out_err hold stable throughout DONE.

## Timing
- Reset values: state = ACC, idx = 0, acc = 0, err_r = 0, out_valid = 0, out_data = 0, out_ovf = 0, out_err = 0. in_ready is 1 in the first cycle after reset.
- Throughput: one digit per cycle while in_valid is held.
- Latency: out_valid rises the cycle after digit D-1 is accepted. A word takes D cycles in plus at least 1 cycle out, so there is a minimum of D+1 cycles between word starts.
- Backpressure: if out_ready is low, DONE persists indefinitely with outputs unchanged and in_ready low.
- in_valid low mid-word: idx and acc hold, with no timeout.
- rst asserted mid-word or in DONE: the partial word and the pending result are discarded, and all registers return to reset values on that edge.
- Digit lines are sampled only on accepted cycles; their values at other times are ignored.

## Test plan
- MODE 0, N=8, stream LSD-first -2,-1,-2,+2 with no stalls → out_valid on cycle 5, out_data = 0x5A, out_ovf = 0, out_err = 0.
- MODE 1, stream -1,0,0,0 → out_data = 0xFF, ovf = 0, err = 0. Then stream +2,+2,+2,+2 → out_data = 0xAA, out_ovf = 1 (sum 170), err = 0.
- Illegal digits:
  - MODE 0, digit 1 with twop = 1 → err = 1, value still included.
  - Digit 0 with onep & onem both high → treated as 0, err = 1.
  - The next clean word reports err = 0.
- Backpressure: hold out_ready low for 3 cycles after DONE → in_ready = 0, and out_data/flags are constant for those 3 cycles. Release → handshake completes, and in_ready = 1 the next cycle.
- Stall and reset: insert in_valid gaps between digits → same result as the no-stall case. Assert rst after 2 digits → in_ready = 1 and out_valid = 0 after the edge, and a fresh 4-digit word decodes correctly.
- Random round-trip: random 8-bit values recoded by the NR4SD-/+ recoder for both MODEs → out_data equals the input, ovf = 0, err = 0.

Source files
------------

// File: rtl/nr4sd_serial_decoder_if.sv
// rtl/nr4sd_serial_decoder_if.sv - digit-in / result-out handshake bundle for the NR4SD serial decoder
//
// Ports carried:
//   in_valid/in_ready            digit handshake
//   onep/onem/twop/twom          one-hot NR4SD digit lines (+1/-1/+2/-2)
//   out_valid/out_ready          result handshake
//   out_data[N-1:0]              reconstructed two's complement value
//   out_ovf/out_err              overflow and digit-legality flags
// master = digit producer / result consumer, slave = decoder.
interface nr4sd_serial_decoder_if #(
  parameter int N = 8
) ();
  logic         in_valid;
  logic         in_ready;
  logic         onep;
  logic         onem;
  logic         twop;
  logic         twom;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_ovf;
  logic         out_err;

  modport master (
    output in_valid, onep, onem, twop, twom, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_err
  );

  modport slave (
    input  in_valid, onep, onem, twop, twom, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_err
  );
endinterface

// File: rtl/nr4sd_serial_decoder.sv
// rtl/nr4sd_serial_decoder.sv - serial NR4SD digit stream to N-bit two's complement decoder
//
// Accepts one digit per handshake, least-significant first, accumulates the
// radix-4 weighted sum and presents the value with overflow/error flags.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   nr4sd_serial_decoder_if.slave (digit input, result output)
// Parameters:
//   N     result width (even, >= 4); D = N/2 digits per word
//   MODE  0 = NR4SD- (non-MSD twop illegal), 1 = NR4SD+ (non-MSD twom illegal)
module nr4sd_serial_decoder #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  nr4sd_serial_decoder_if.slave bus
);
  localparam int D  = N / 2;
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(D - 1);

  typedef enum logic {ACC, DONE} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic signed [N+1:0]   acc_q, acc_d;
  logic                  err_q, err_d;
  logic [N-1:0]          data_q, data_d;
  logic                  ovf_q, ovf_d;

  logic                  accept;
  logic                  multi;
  logic                  forbid;
  logic                  dig_err;
  logic signed [2:0]     dval;
  logic signed [N+1:0]   term;
  logic signed [N+1:0]   sum;
  logic                  err_next;

  assign accept = bus.in_valid && (state_q == ACC);

  // Digit decode: more than one line high collapses the digit to zero.
  always_comb begin
    multi = (bus.onep & bus.onem) | (bus.onep & bus.twop) | (bus.onep & bus.twom) |
            (bus.onem & bus.twop) | (bus.onem & bus.twom) | (bus.twop & bus.twom);
    dval = 3'sd0;
    if (!multi) begin
      if (bus.onep)      dval = 3'sd1;
      else if (bus.onem) dval = -3'sd1;
      else if (bus.twop) dval = 3'sd2;
      else if (bus.twom) dval = -3'sd2;
    end
    // Only the MSD may take the value that lies outside the mode's digit set.
    forbid  = (idx_q != LAST_IDX) && ((MODE == 0) ? bus.twop : bus.twom);
    dig_err = multi | forbid;
  end

  // Weighted term and running sum; N+2 bits hold any legal or illegal word.
  always_comb begin
    term     = {{(N-1){dval[2]}}, dval} <<< {idx_q, 1'b0};
    // The first digit of a word starts fresh instead of adding to the last word.
    sum      = (idx_q == '0) ? term : (acc_q + term);
    err_next = ((idx_q == '0) ? 1'b0 : err_q) | dig_err;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    err_d   = err_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACC: begin
        if (accept) begin
          acc_d = sum;
          err_d = err_next;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            data_d  = sum[N-1:0];
            // Fits in N signed bits only when the top three bits agree.
            ovf_d   = !((sum[N+1:N-1] == 3'b000) || (sum[N+1:N-1] == 3'b111));
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = ACC;
          idx_d   = '0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      idx_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = data_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_err   = err_q;
endmodule

// File: tb/tb_nr4sd_serial_decoder.sv
// tb/tb_nr4sd_serial_decoder.sv - self-checking bench for nr4sd_serial_decoder (both MODEs)
module tb_nr4sd_serial_decoder;
  logic clk;
  logic rst;
  logic in_valid, onep, onem, twop, twom, out_ready;

  int tests;
  int fails;

  nr4sd_serial_decoder_if #(.N(8)) if0 ();
  nr4sd_serial_decoder_if #(.N(8)) if1 ();

  // Both decoders see identical stimulus; only the legality rules differ.
  assign if0.in_valid  = in_valid;
  assign if0.onep      = onep;
  assign if0.onem      = onem;
  assign if0.twop      = twop;
  assign if0.twom      = twom;
  assign if0.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.onep      = onep;
  assign if1.onem      = onem;
  assign if1.twop      = twop;
  assign if1.twom      = twom;
  assign if1.out_ready = out_ready;

  nr4sd_serial_decoder #(.N(8), .MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  nr4sd_serial_decoder #(.N(8), .MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // digit, data, ovf, err(MODE0), err(MODE1); digit code 7 = onep and onem both high
  typedef struct {
    int d0; int d1; int d2; int d3;
    int data; int ovf; int err0; int err1;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_digit(input int d);
    onep = (d == 1) || (d == 7);
    onem = (d == -1) || (d == 7);
    twop = (d == 2);
    twom = (d == -2);
  endtask

  task automatic push_digit(input int d, input int gap);
    set_digit(d);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    onep = 1'b1; twom = 1'b1; onem = 1'b0; twop = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits (bounded) for out_valid, checks the result, completes the handshake.
  task automatic finish_word(input string name, input int data, input int ovf,
                             input int err0, input int err1);
    int n;
    n = 0;
    while (!if0.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_valid"}, int'(if0.out_valid), 1);
    check({name, "_data0"}, int'(if0.out_data), data);
    check({name, "_data1"}, int'(if1.out_data), data);
    check({name, "_ovf0"},  int'(if0.out_ovf), ovf);
    check({name, "_ovf1"},  int'(if1.out_ovf), ovf);
    if (err0 >= 0) check({name, "_err0"}, int'(if0.out_err), err0);
    if (err1 >= 0) check({name, "_err1"}, int'(if1.out_err), err1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, "_ready_after"}, int'(if0.in_ready), 1);
  endtask

  task automatic send_recoded(input int x, input int mode);
    int v, r, d;
    v = x;
    for (int i = 0; i < 3; i++) begin
      r = v & 3;
      if (mode == 0) d = (r == 2) ? -2 : ((r == 3) ? -1 : r);
      else           d = (r == 3) ? -1 : r;
      push_digit(d, 0);
      v = (v - d) >>> 2;
    end
    push_digit(v, 0);
    if (mode == 0) finish_word("rand_m0", x & 255, 0, 0, -1);
    else           finish_word("rand_m1", x & 255, 0, -1, 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    set_digit(0);

    vecs[0]  = '{-2, -1, -2,  2, 'h5A, 0, 0, 1};
    vecs[1]  = '{-1,  0,  0,  0, 'hFF, 0, 0, 0};
    vecs[2]  = '{ 2,  2,  2,  2, 'hAA, 1, 1, 0};
    vecs[3]  = '{ 0,  2,  0,  0, 'h08, 0, 1, 0};
    vecs[4]  = '{ 7,  0,  0,  0, 'h00, 0, 1, 1};
    vecs[5]  = '{ 1,  0,  0,  0, 'h01, 0, 0, 0};
    vecs[6]  = '{-2, -2, -2, -2, 'h56, 1, 0, 1};
    vecs[7]  = '{ 1,  1,  1, -1, 'hD5, 0, 0, 0};
    vecs[8]  = '{ 0,  0,  0, -2, 'h80, 0, 0, 0};
    vecs[9]  = '{ 0,  0,  0,  2, 'h80, 1, 0, 0};
    vecs[10] = '{-1, -1, -1, -1, 'hAB, 0, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready",  int'(if0.in_ready), 1);
    check("rst_out_valid", int'(if0.out_valid), 0);
    check("rst_out_data",  int'(if0.out_data), 0);
    check("rst_out_ovf",   int'(if0.out_ovf), 0);
    check("rst_out_err",   int'(if0.out_err), 0);

    // Latency: no result after 3 digits, result right after the 4th edge.
    push_digit(-2, 0); push_digit(-1, 0); push_digit(-2, 0);
    check("lat_not_yet", int'(if0.out_valid), 0);
    push_digit(2, 0);
    check("lat_valid", int'(if0.out_valid), 1);
    finish_word("lat", 'h5A, 0, 0, 1);

    foreach (vecs[k]) begin
      push_digit(vecs[k].d0, 0);
      push_digit(vecs[k].d1, 0);
      push_digit(vecs[k].d2, 0);
      push_digit(vecs[k].d3, 0);
      finish_word($sformatf("vec%0d", k), vecs[k].data, vecs[k].ovf,
                  vecs[k].err0, vecs[k].err1);
    end

    // Backpressure with an offered (ignored) digit while DONE.
    push_digit(1, 0); push_digit(1, 0); push_digit(1, 0); push_digit(-1, 0);
    set_digit(2);
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("bp_in_ready",  int'(if0.in_ready), 0);
      check("bp_out_valid", int'(if0.out_valid), 1);
      check("bp_data",      int'(if0.out_data), 'hD5);
      check("bp_ovf",       int'(if0.out_ovf), 0);
      check("bp_err",       int'(if0.out_err), 0);
    end
    in_valid = 1'b0;
    finish_word("bp", 'hD5, 0, 0, 0);
    push_digit(-1, 0); push_digit(0, 0); push_digit(0, 0); push_digit(0, 0);
    finish_word("bp_next", 'hFF, 0, 0, 0);

    // Stalls between digits with junk on the lines.
    push_digit(-2, 2); push_digit(-1, 1); push_digit(-2, 3); push_digit(2, 0);
    finish_word("stall", 'h5A, 0, 0, 1);

    // Reset mid-word.
    push_digit(7, 0); push_digit(2, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rstmid_in_ready",  int'(if0.in_ready), 1);
    check("rstmid_out_valid", int'(if0.out_valid), 0);
    push_digit(-1, 0); push_digit(-1, 0); push_digit(-1, 0); push_digit(-1, 0);
    finish_word("rstmid", 'hAB, 0, 0, 0);

    // Reset while a result is pending.
    push_digit(2, 0); push_digit(2, 0); push_digit(2, 0); push_digit(2, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rstdone_out_valid", int'(if0.out_valid), 0);
    check("rstdone_in_ready",  int'(if0.in_ready), 1);
    check("rstdone_data",      int'(if0.out_data), 0);
    check("rstdone_ovf",       int'(if0.out_ovf), 0);
    check("rstdone_err",       int'(if0.out_err), 0);

    // Random round trip through a reference recoder, both digit sets.
    for (int m = 0; m < 2; m++) begin
      for (int j = 0; j < 12; j++) begin
        send_recoded(int'($urandom_range(0, 255)) - 128, m);
      end
    end
    send_recoded(127, 0);
    send_recoded(-128, 0);
    send_recoded(127, 1);
    send_recoded(-128, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
